// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared mode encodings, default sizes and the select-width helper
// for the mux_scan registered multiplexer.
package mux_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_N_CH    = 6;
  localparam int DEF_W       = 4;
  localparam int DEF_DWELL_W = 8;

  // Smallest index width able to address n_ch channels (at least 1 bit).
  function automatic int min_sel_w(input int n_ch);
    int w;
    w = 1;
    while ((1 << w) < n_ch) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: dwell counter and channel-index sequencer for mux_scan.
// Presents the index to display this cycle and a wrap flag aligned with it.
// Optional channel skipping is compiled in with the MUX_SCAN_SKIP_EN macro.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int SEL_W   = min_sel_w(DEF_N_CH),
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mode,
  input  logic               i_hold,
  input  logic [DWELL_W-1:0] i_dwell,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N_CH-1:0]    i_ch_mask,
`endif
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

  mode_e              mode_q, mode_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;

  logic               entry;
  logic [SEL_W-1:0]   cur_idx;
  logic [DWELL_W-1:0] cur_cnt;
  logic [SEL_W-1:0]   nxt_idx;
  logic               nxt_wrap;

  // A rising mode (against the stored mode) restarts the scan from channel 0.
  always_comb begin
    entry   = (i_mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
    cur_idx = entry ? '0 : idx_q;
    cur_cnt = entry ? '0 : cnt_q;
  end

`ifdef MUX_SCAN_SKIP_EN
  int   cand;
  logic found;

  // Next enabled channel after cur_idx (circular); stays put when none is enabled.
  always_comb begin
    nxt_idx  = cur_idx;
    nxt_wrap = 1'b0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = int'(cur_idx) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!found && |(i_ch_mask & (N_CH'(1) << cand))) begin
        found    = 1'b1;
        nxt_idx  = SEL_W'(cand);
        nxt_wrap = (cand <= int'(cur_idx));
      end
    end
  end
`else
  // Plain round-robin advance over all channels.
  always_comb begin
    nxt_wrap = (cur_idx == LAST_IDX);
    nxt_idx  = nxt_wrap ? '0 : cur_idx + SEL_W'(1);
  end
`endif

  // Dwell/index update: equality with the live dwell value is the only advance point.
  always_comb begin
    mode_d = mode_e'(i_mode);
    idx_d  = cur_idx;
    cnt_d  = cur_cnt;
    wrap_d = 1'b0;
    if (i_mode == MODE_MANUAL) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (!i_hold) begin
      if (cur_cnt == i_dwell) begin
        cnt_d  = '0;
        idx_d  = nxt_idx;
        wrap_d = nxt_wrap;
      end else begin
        cnt_d = cur_cnt + DWELL_W'(1);
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_MANUAL;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_idx  = cur_idx;
  assign o_wrap = wrap_q && !entry;

endmodule

// File: rtl/mux_scan.sv
// mux_scan: N-channel registered multiplexer with manual select or self-scan.
// Optional channel-skip mask (i_ch_mask) is enabled by defining MUX_SCAN_SKIP_EN.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int W       = DEF_W,
  parameter int SEL_W   = min_sel_w(DEF_N_CH),
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_CH*W-1:0]   i_data,
  input  logic                i_mode,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic                i_hold,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N_CH-1:0]     i_ch_mask,
`endif
  output logic [W-1:0]        o_data,
  output logic [SEL_W-1:0]    o_ch,
  output logic                o_valid,
  output logic                o_wrap
);

  localparam logic [SEL_W:0] NCH_EXT = (SEL_W + 1)'(N_CH);

  logic [W-1:0]     ch [N_CH];
  logic [SEL_W-1:0] seq_idx;
  logic             seq_wrap;
  logic [SEL_W-1:0] sel;
  logic             legal;

  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch[gi] = i_data[gi*W +: W];
    end
  endgenerate

  mux_scan_seq #(
    .N_CH    (N_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_seq (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_mode    (i_mode),
    .i_hold    (i_hold),
    .i_dwell   (i_dwell),
`ifdef MUX_SCAN_SKIP_EN
    .i_ch_mask (i_ch_mask),
`endif
    .o_idx     (seq_idx),
    .o_wrap    (seq_wrap)
  );

  // Pick the channel for this edge and decide whether it is a legal one.
  always_comb begin
    sel   = (i_mode == MODE_SCAN) ? seq_idx : i_sel;
    legal = ({1'b0, sel} < NCH_EXT);
`ifdef MUX_SCAN_SKIP_EN
    legal = legal && |(i_ch_mask & (N_CH'(1) << sel));
`endif
    data_d  = legal ? ch[sel] : '0;
    ch_d    = sel;
    valid_d = legal;
    wrap_d  = (i_mode == MODE_SCAN) && seq_wrap;
  end

  // Output registers: one cycle from inputs to outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_data  = data_q;
  assign o_ch    = ch_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: self-checking bench for mux_scan (N_CH=6, W=4, SEL_W=3, DWELL_W=8).
// Skip-mask sequences are included when MUX_SCAN_SKIP_EN is defined.
module tb_mux_scan;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [23:0] i_data  = '0;
  logic        i_mode  = 1'b0;
  logic [2:0]  i_sel   = '0;
  logic [7:0]  i_dwell = '0;
  logic        i_hold  = 1'b0;
`ifdef MUX_SCAN_SKIP_EN
  logic [5:0]  i_ch_mask = 6'h3F;
`endif
  logic [3:0]  o_data;
  logic [2:0]  o_ch;
  logic        o_valid;
  logic        o_wrap;

  mux_scan #(.N_CH(6), .W(4), .SEL_W(3), .DWELL_W(8)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_mode    (i_mode),
    .i_sel     (i_sel),
    .i_dwell   (i_dwell),
    .i_hold    (i_hold),
`ifdef MUX_SCAN_SKIP_EN
    .i_ch_mask (i_ch_mask),
`endif
    .o_data    (o_data),
    .o_ch      (o_ch),
    .o_valid   (o_valid),
    .o_wrap    (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [23:0] BASE = 24'hFEDCBA;

  typedef struct {
    logic [3:0] data;
    logic [2:0] ch;
    logic       valid;
    logic       wrap;
    string      name;
  } exp_t;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  sel;
    logic [3:0]  ed;
    logic [2:0]  ec;
    logic        ev;
  } mvec_t;

  exp_t  sb[$];
  mvec_t mtab[9];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic compare(input exp_t e);
    n_total++;
    if (o_data === e.data && o_ch === e.ch && o_valid === e.valid && o_wrap === e.wrap) begin
      n_pass++;
      $display("ok   %s: data=%h ch=%0d valid=%b wrap=%b", e.name, o_data, o_ch, o_valid, o_wrap);
    end else begin
      $display("FAIL %s: got data=%h ch=%0d valid=%b wrap=%b, want data=%h ch=%0d valid=%b wrap=%b",
               e.name, o_data, o_ch, o_valid, o_wrap, e.data, e.ch, e.valid, e.wrap);
    end
  endtask

  task automatic check_now(input string nm);
    exp_t e;
    e.data = '0; e.ch = '0; e.valid = 1'b0; e.wrap = 1'b0; e.name = nm;
    compare(e);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic [23:0] d, input logic m, input logic [2:0] s,
                      input logic [7:0] dw, input logic h,
                      input logic [3:0] ed, input logic [2:0] ec,
                      input logic ev, input logic ew, input string nm);
    exp_t e;
    i_data = d; i_mode = m; i_sel = s; i_dwell = dw; i_hold = h;
    e.data = ed; e.ch = ec; e.valid = ev; e.wrap = ew; e.name = nm;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    compare(sb.pop_front());
  endtask

  initial begin
    int c;
    logic [3:0] h4;

    mtab[0] = '{BASE, 3'd0, 4'hA, 3'd0, 1'b1};
    mtab[1] = '{BASE, 3'd2, 4'hC, 3'd2, 1'b1};
    mtab[2] = '{BASE, 3'd5, 4'hF, 3'd5, 1'b1};
    mtab[3] = '{BASE, 3'd6, 4'h0, 3'd6, 1'b0};
    mtab[4] = '{BASE, 3'd7, 4'h0, 3'd7, 1'b0};
    mtab[5] = '{BASE, 3'd3, 4'hD, 3'd3, 1'b1};
    mtab[6] = '{24'h123456, 3'd1, 4'h5, 3'd1, 1'b1};
    mtab[7] = '{24'h123456, 3'd4, 4'h2, 3'd4, 1'b1};
    mtab[8] = '{24'h123456, 3'd6, 4'h0, 3'd6, 1'b0};

    // Reset dominates even with scan requested and edges arriving.
    i_data = BASE; i_mode = 1'b1; i_sel = 3'd2;
    #3 i_rst_n = 1'b0;
    #1 check_now("reset_async");
    @(posedge i_clk); @(posedge i_clk); #1;
    check_now("reset_hold");
    i_rst_n = 1'b1;
    i_mode  = 1'b0;

    // Manual select table.
    for (int i = 0; i < 9; i++)
      step(mtab[i].data, 1'b0, mtab[i].sel, 8'd0, 1'b0,
           mtab[i].ed, mtab[i].ec, mtab[i].ev, 1'b0, $sformatf("manual[%0d]", i));

    // Scan, dwell 2: three cycles per channel, wrap on the first channel-0 cycle.
    step(BASE, 1'b0, 3'd0, 8'd2, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "scan_pre");
    for (int i = 0; i < 21; i++) begin
      c = (i / 3) % 6;
      step(BASE, 1'b1, 3'd0, 8'd2, 1'b0, 4'(10 + c), 3'(c), 1'b1, i == 18,
           $sformatf("scan_dw2[%0d]", i));
    end

    // Hold on channel 4 for 5 cycles with a live data change, then resume.
    step(BASE, 1'b0, 3'd0, 8'd2, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "hold_pre");
    for (int i = 0; i < 24; i++) begin
      h4 = (i >= 16) ? 4'h7 : 4'hE;
      if (i < 12)      c = i / 3;
      else if (i < 20) c = 4;
      else if (i < 23) c = 5;
      else             c = 0;
      step({4'hF, h4, 16'hDCBA}, 1'b1, 3'd0, 8'd2, (i >= 14 && i <= 18),
           (c == 4) ? h4 : 4'(10 + c), 3'(c), 1'b1, i == 23, $sformatf("hold[%0d]", i));
    end

    // Mode switching: scan -> manual -> scan restarts at channel 0.
    step(BASE, 1'b0, 3'd1, 8'd0, 1'b0, 4'hB, 3'd1, 1'b1, 1'b0, "mode_pre");
    for (int i = 0; i < 4; i++)
      step(BASE, 1'b1, 3'd1, 8'd0, 1'b0, 4'(10 + i), 3'(i), 1'b1, 1'b0, $sformatf("mode_scan[%0d]", i));
    step(BASE, 1'b0, 3'd1, 8'd0, 1'b0, 4'hB, 3'd1, 1'b1, 1'b0, "mode_to_manual");
    step(BASE, 1'b1, 3'd1, 8'd0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "mode_to_scan");
    step(BASE, 1'b1, 3'd1, 8'd0, 1'b0, 4'hB, 3'd1, 1'b1, 1'b0, "mode_scan_next");

    // Dwell lowered below the running count: counter rolls over before advancing.
    step(BASE, 1'b0, 3'd0, 8'd5, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "dwell_pre");
    for (int i = 0; i < 262; i++) begin
      c = (i < 258) ? 0 : ((i < 260) ? 1 : 2);
      step(BASE, 1'b1, 3'd0, (i < 4) ? 8'd5 : 8'd1, 1'b0, 4'(10 + c), 3'(c), 1'b1, 1'b0,
           $sformatf("dwell_chg[%0d]", i));
    end

    // Reset in the middle of a scan, then restart from channel 0.
    step(BASE, 1'b0, 3'd0, 8'd0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "rst_pre");
    for (int i = 0; i < 4; i++)
      step(BASE, 1'b1, 3'd0, 8'd0, 1'b0, 4'(10 + i), 3'(i), 1'b1, 1'b0, $sformatf("rst_scan[%0d]", i));
    #2 i_rst_n = 1'b0;
    #1 check_now("rst_mid_async");
    @(posedge i_clk); #1;
    check_now("rst_mid_hold");
    i_rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      c = i % 6;
      step(BASE, 1'b1, 3'd0, 8'd0, 1'b0, 4'(10 + c), 3'(c), 1'b1, i == 6, $sformatf("rst_after[%0d]", i));
    end

`ifdef MUX_SCAN_SKIP_EN
    // Skip mask 100101: scan visits 0,2,5 with wrap on each return to 0.
    i_ch_mask = 6'b100101;
    step(BASE, 1'b0, 3'd0, 8'd0, 1'b0, 4'hA, 3'd0, 1'b1, 1'b0, "skip_pre");
    for (int i = 0; i < 7; i++) begin
      c = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 5);
      step(BASE, 1'b1, 3'd0, 8'd0, 1'b0, 4'(10 + c), 3'(c), 1'b1, (i == 3 || i == 6),
           $sformatf("skip[%0d]", i));
    end
    step(BASE, 1'b0, 3'd1, 8'd0, 1'b0, 4'h0, 3'd1, 1'b0, 1'b0, "skip_manual_masked");
    step(BASE, 1'b0, 3'd2, 8'd0, 1'b0, 4'hC, 3'd2, 1'b1, 1'b0, "skip_manual_enabled");
    i_ch_mask = 6'b000000;
    for (int i = 0; i < 3; i++)
      step(BASE, 1'b1, 3'd0, 8'd0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, $sformatf("skip_none[%0d]", i));
    i_ch_mask = 6'h3F;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
